// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back source select, forwarding outputs
// and a running count of register-file writes.
`timescale 1ns/1ps
module mem_wb_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [50:0] data_in,
   input  logic [2:0]  rdst_idx,
   input  logic        in_valid,
   input  logic        stall,
   input  logic        flush,
   output logic        rf_we,
   output logic [2:0]  rf_addr,
   output logic [15:0] rf_wdata,
   output logic        fwd_valid,
   output logic [2:0]  fwd_addr,
   output logic [15:0] fwd_data,
   output logic [15:0] retire_cnt
);

   logic        r_v;
   logic [2:0]  r_wb;
   logic [15:0] r_imm;
   logic [15:0] r_alu;
   logic [15:0] r_mem;
   logic [2:0]  r_idx;
   logic [15:0] r_retire_cnt;

   logic        w_writes;
   logic        w_rf_we;
   logic [15:0] w_wdata;

   // Flush beats stall; on flush only v matters, the payload is left as is.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v   <= 1'b0;
         r_wb  <= 3'd0;
         r_imm <= 16'd0;
         r_alu <= 16'd0;
         r_mem <= 16'd0;
         r_idx <= 3'd0;
      end else if (flush) begin
         r_v <= 1'b0;
      end else if (!stall) begin
         r_v   <= in_valid;
         r_wb  <= data_in[50:48];
         r_imm <= data_in[47:32];
         r_alu <= data_in[31:16];
         r_mem <= data_in[15:0];
         r_idx <= rdst_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_retire_cnt <= 16'd0;
      end else if (w_rf_we) begin
         r_retire_cnt <= r_retire_cnt + 16'd1;
      end
   end

   always_comb begin
      w_wdata = r_alu;
      case (r_wb[2:1])
         2'b00:   w_wdata = r_mem;
         2'b01:   w_wdata = r_alu;
         2'b10:   w_wdata = r_imm;
         default: w_wdata = r_alu;
      endcase
   end

   // Forwarding stays live during a stall; the write itself waits for release.
   assign w_writes = r_v & r_wb[0];
   assign w_rf_we  = w_writes & ~stall;

   assign rf_we      = w_rf_we;
   assign rf_addr    = r_idx;
   assign rf_wdata   = w_wdata;
   assign fwd_valid  = w_writes;
   assign fwd_addr   = r_idx;
   assign fwd_data   = w_wdata;
   assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: expected writes are queued at drive time
// and matched against register-file writes as they occur.
`timescale 1ns/1ps
module tb_mem_wb_stage;

   typedef struct {
      logic [2:0]  addr;
      logic [15:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [50:0] data_in = '0;
   logic [2:0]  rdst_idx = '0;
   logic        in_valid = 1'b0;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        rf_we;
   logic [2:0]  rf_addr;
   logic [15:0] rf_wdata;
   logic        fwd_valid;
   logic [2:0]  fwd_addr;
   logic [15:0] fwd_data;
   logic [15:0] retire_cnt;

   int          checks = 0;
   int          failures = 0;
   wr_t         exp_q[$];
   logic [15:0] exp_cnt = 16'd0;
   logic [15:0] cnt_before;

   mem_wb_stage dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .rdst_idx   (rdst_idx),
      .in_valid   (in_valid),
      .stall      (stall),
      .flush      (flush),
      .rf_we      (rf_we),
      .rf_addr    (rf_addr),
      .rf_wdata   (rf_wdata),
      .fwd_valid  (fwd_valid),
      .fwd_addr   (fwd_addr),
      .fwd_data   (fwd_data),
      .retire_cnt (retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [50:0] bus(input logic [2:0] wb, input logic [15:0] imm,
                                       input logic [15:0] alu, input logic [15:0] mem);
      return {wb, imm, alu, mem};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [2:0] wb, input logic [15:0] imm, input logic [15:0] alu,
                       input logic [15:0] mem, input logic [2:0] idx, input logic expect_wr);
      wr_t e;
      data_in  = bus(wb, imm, alu, mem);
      rdst_idx = idx;
      in_valid = 1'b1;
      if (expect_wr) begin
         e.addr = idx;
         case (wb[2:1])
            2'b00:   e.data = mem;
            2'b10:   e.data = imm;
            default: e.data = alu;
         endcase
         exp_q.push_back(e);
      end
   endtask

   // Monitor: each write seen before an active edge must match the queue head.
   always @(negedge clk) begin
      wr_t e;
      if (rst) begin
         exp_cnt = 16'd0;
      end else if (rf_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", {29'd0, rf_addr}, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {29'd0, rf_addr}, {29'd0, e.addr});
            chk("wr_data", {16'd0, rf_wdata}, {16'd0, e.data});
         end
         exp_cnt = exp_cnt + 16'd1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      rst = 1'b1;
      tick();
      tick();
      chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
      chk("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
      chk("rst_rf_addr", {29'd0, rf_addr}, 32'd0);
      chk("rst_rf_wdata", {16'd0, rf_wdata}, 32'd0);
      chk("rst_retire_cnt", {16'd0, retire_cnt}, 32'd0);
      rst = 1'b0;
      tick();

      // Basic load, one-cycle latency, mem source
      load(3'b001, 16'h1111, 16'h2222, 16'h3333, 3'd5, 1'b1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("ld_rf_we", {31'd0, rf_we}, 32'd1);
      chk("ld_rf_addr", {29'd0, rf_addr}, 32'd5);
      chk("ld_rf_wdata", {16'd0, rf_wdata}, 32'h3333);
      chk("ld_cnt_before", {16'd0, retire_cnt}, 32'd0);
      tick();
      chk("ld_cnt_after", {16'd0, retire_cnt}, 32'd1);

      // Source select, back to back
      load(3'b011, 16'hAAAA, 16'hBBBB, 16'hCCCC, 3'd1, 1'b1);
      tick();
      chk("sel011", {16'd0, rf_wdata}, 32'hBBBB);
      load(3'b101, 16'hAAAA, 16'hBBBB, 16'hCCCC, 3'd2, 1'b1);
      tick();
      chk("sel101", {16'd0, rf_wdata}, 32'hAAAA);
      load(3'b111, 16'hAAAA, 16'hBBBB, 16'hCCCC, 3'd3, 1'b1);
      tick();
      chk("sel111", {16'd0, rf_wdata}, 32'hBBBB);
      load(3'b000, 16'hAAAA, 16'hBBBB, 16'hCCCC, 3'd4, 1'b0);
      tick();
      cnt_before = retire_cnt;
      in_valid = 1'b0;
      #1;
      chk("nowb_rf_we", {31'd0, rf_we}, 32'd0);
      chk("nowb_fwd_valid", {31'd0, fwd_valid}, 32'd0);
      tick();
      chk("nowb_cnt", {16'd0, retire_cnt}, {16'd0, cnt_before});
      chk("cnt_model", {16'd0, retire_cnt}, {16'd0, exp_cnt});

      // Stall holds the instruction; single write on release
      load(3'b011, 16'h0000, 16'h1234, 16'h0000, 3'd7, 1'b1);
      tick();
      cnt_before = retire_cnt;
      stall = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_fwd_valid", {31'd0, fwd_valid}, 32'd1);
         chk("stall_fwd_data", {16'd0, fwd_data}, 32'h1234);
         chk("stall_rf_we", {31'd0, rf_we}, 32'd0);
         tick();
      end
      stall = 1'b0;
      #1;
      chk("release_rf_we", {31'd0, rf_we}, 32'd1);
      chk("release_fwd_addr", {29'd0, fwd_addr}, 32'd7);
      tick();
      chk("release_rf_we_done", {31'd0, rf_we}, 32'd0);
      chk("stall_cnt", {16'd0, retire_cnt}, {16'd0, cnt_before + 16'd1});

      // Flush wins over stall
      load(3'b011, 16'h0000, 16'h4321, 16'h0000, 3'd2, 1'b0);
      tick();
      stall = 1'b1;
      flush = 1'b1;
      load(3'b011, 16'h0000, 16'h9999, 16'h0000, 3'd3, 1'b0);
      #1;
      chk("fl_pre_rf_we", {31'd0, rf_we}, 32'd0);
      tick();
      stall = 1'b0;
      flush = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("fl_rf_we", {31'd0, rf_we}, 32'd0);
      chk("fl_fwd_valid", {31'd0, fwd_valid}, 32'd0);

      // Flush held across cycles with valid input
      flush = 1'b1;
      load(3'b001, 16'h0000, 16'h0000, 16'h5A5A, 3'd1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("flhold_rf_we", {31'd0, rf_we}, 32'd0);
         chk("flhold_fwd_valid", {31'd0, fwd_valid}, 32'd0);
      end
      flush = 1'b0;
      in_valid = 1'b0;
      tick();
      chk("cnt_model2", {16'd0, retire_cnt}, {16'd0, exp_cnt});

      // Reset while an instruction is held by stall
      load(3'b011, 16'h0000, 16'h5555, 16'h0000, 3'd6, 1'b0);
      tick();
      stall = 1'b1;
      in_valid = 1'b0;
      #1;
      chk("rs_fwd_valid_pre", {31'd0, fwd_valid}, 32'd1);
      rst = 1'b1;
      tick();
      chk("rs_rf_we", {31'd0, rf_we}, 32'd0);
      chk("rs_fwd_valid", {31'd0, fwd_valid}, 32'd0);
      chk("rs_rf_addr", {29'd0, rf_addr}, 32'd0);
      chk("rs_rf_wdata", {16'd0, rf_wdata}, 32'd0);
      chk("rs_cnt", {16'd0, retire_cnt}, 32'd0);
      rst = 1'b0;
      stall = 1'b0;
      #1;
      chk("rs_release_rf_we", {31'd0, rf_we}, 32'd0);
      tick();
      tick();
      chk("rs_cnt_after", {16'd0, retire_cnt}, 32'd0);

      // Counter wrap: 0xFFFF retirements, then one more
      for (int i = 0; i < 65535; i++) begin
         load(3'b001, 16'h0000, 16'h0000, i[15:0], i[2:0], 1'b1);
         tick();
      end
      in_valid = 1'b0;
      tick();
      chk("wrap_ffff", {16'd0, retire_cnt}, 32'h0000_FFFF);
      load(3'b001, 16'h0000, 16'h0000, 16'hBEEF, 3'd4, 1'b1);
      tick();
      in_valid = 1'b0;
      #1;
      chk("wrap_rf_we", {31'd0, rf_we}, 32'd1);
      tick();
      chk("wrap_zero", {16'd0, retire_cnt}, 32'd0);

      tick();
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); rst input 1 (synchronous, active-high reset).
REQ-002 SHALL have port data_in, input, 51 bits: memory-stage result bus {WB[2:0] at 50:48, Imm at 47:32, ALU at 31:16, mem read data at 15:0}.
REQ-003 SHALL have port rdst_idx, input, 3 bits: destination register index travelling with data_in.
REQ-004 SHALL have port in_valid, input, 1 bit: data_in/rdst_idx hold a real instruction this cycle.
REQ-005 SHALL have port stall, input, 1 bit: hold the stage register.
REQ-006 SHALL have port flush, input, 1 bit: kill the stage contents.
REQ-007 SHALL have port rf_we, output, 1 bit: register-file write enable.
REQ-008 SHALL have port rf_addr, output, 3 bits: register-file write index.
REQ-009 SHALL have port rf_wdata, output, 16 bits: register-file write data.
REQ-010 SHALL have port fwd_valid, output, 1 bit: forwarding value available.
REQ-011 SHALL have port fwd_addr, output, 3 bits: forwarding register index.
REQ-012 SHALL have port fwd_data, output, 16 bits: forwarding value.
REQ-013 SHALL have port retire_cnt, output, 16 bits: count of instructions retired with rf_we=1.

Function
REQ-014 SHALL hold a stage register with fields v (1), wb (3), imm (16), alu (16), mem (16), idx (3).
REQ-015 SHALL, each rising edge with rst=0, update the stage register by priority: flush, then stall, then load.
- flush=1: v<=0; other fields don't-care.
- flush=0, stall=1: all fields hold.
- otherwise: v<=in_valid; wb/imm/alu/mem/idx <= data_in slices and rdst_idx.
REQ-016 SHALL treat flush and stall asserted together as flush.
REQ-017 SHALL select the write-back source from registered wb[2:1]:
- 00: mem.
- 01: alu.
- 10: imm.
- 11: alu (reserved encoding).
REQ-018 SHALL drive rf_we = v AND wb[0] AND NOT stall, combinationally from the register, so a stalled instruction writes exactly once, on the cycle its stall is released.
REQ-019 SHALL drive rf_addr = idx and rf_wdata = selected source, independent of v; both are don't-care when rf_we=0.
REQ-020 SHALL drive fwd_valid = v AND wb[0] (not gated by stall), fwd_addr = idx, fwd_data = rf_wdata.
REQ-021 SHALL give a latency of one clock from in_valid sampled (stall=0, flush=0) to rf_we asserted.
REQ-022 SHALL increment retire_cnt by 1 on each rising edge where rf_we=1, wrapping from 0xFFFF to 0x0000 modulo 2^16.
REQ-023 SHALL NOT count, write or forward an instruction with wb[0]=0; it occupies the stage with no side effects.
REQ-024 SHALL stay at v=0 while flush is held across consecutive cycles, producing no rf_we pulses.

Reset
REQ-025 SHALL, on a rising edge with rst=1, clear v, wb, imm, alu, mem, idx and retire_cnt to 0, overriding flush, stall and in_valid.
REQ-026 SHALL have all outputs at 0 in the cycle after reset (rf_we=0, fwd_valid=0, rf_addr=0, rf_wdata=0, retire_cnt=0).
REQ-027 SHALL discard an in-flight stalled instruction when rst is asserted mid-operation; it is never written and never counted.

Verification
REQ-028 SHALL cover back-to-back load: data_in={3'b001,0x1111,0x2222,0x3333}, rdst_idx=5, in_valid=1 -> next cycle rf_we=1, rf_addr=5, rf_wdata=0x3333, retire_cnt 0->1.
REQ-029 SHALL cover source select: WB=011/101/111 with Imm=0xAAAA, ALU=0xBBBB -> rf_wdata 0xBBBB, 0xAAAA, 0xBBBB respectively; WB=000 -> rf_we=0, fwd_valid=0, count unchanged.
REQ-030 SHALL cover stall: load WB=011, ALU=0x1234, then stall=1 for 3 cycles -> fwd_valid=1, fwd_data=0x1234 throughout, rf_we=0; rf_we=1 exactly once after release; count +1.
REQ-031 SHALL cover flush priority: stall=1 and flush=1 together with a valid instruction in the stage -> next cycle v=0, rf_we=0, fwd_valid=0.
REQ-032 SHALL cover wrap: preload 0xFFFF retirements, retire one more -> retire_cnt=0x0000.
REQ-033 SHALL cover reset mid-stall: valid WB=011 held by stall, assert rst for one cycle -> all outputs 0, no write after stall release.
